// File: rtl/dpram_write_arbiter.sv
// Round-robin write-port arbiter with bounded bursts and a 1-cycle read sequencer for a dual-port RAM.
// Optional macro DPRAM_WR_FWD_EN adds same-cycle write-to-read forwarding (new data on collision).
//
// state  | meaning
// IDLE   | no grant held, RAM port A idle
// GRANT0 | requester 0 owns port A
// GRANT1 | requester 1 owns port A
module dpram_write_arbiter #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024,
  parameter int MAX_BURST = 8,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_req_i,
  input  logic [AW-1:0]        m0_addr_i,
  input  logic [RAM_WIDTH-1:0] m0_data_i,
  input  logic                 m1_req_i,
  input  logic [AW-1:0]        m1_addr_i,
  input  logic [RAM_WIDTH-1:0] m1_data_i,
  output logic                 m0_gnt_o,
  output logic                 m1_gnt_o,
  input  logic                 rd_req_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [RAM_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 ram_we_a_o,
  output logic [AW-1:0]        ram_addr_a_o,
  output logic [RAM_WIDTH-1:0] ram_din_a_o,
  output logic                 ram_re_b_o,
  output logic [AW-1:0]        ram_addr_b_o,
  input  logic [RAM_WIDTH-1:0] ram_dout_b_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic            last_served_q, last_served_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            rd_valid_q, rd_valid_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    ram_we_a_o    = 1'b0;
    ram_addr_a_o  = '0;
    ram_din_a_o   = '0;

    case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          state_d = last_served_q ? GRANT0 : GRANT1;
        end else if (m0_req_i) begin
          state_d = GRANT0;
        end else if (m1_req_i) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        ram_we_a_o   = m0_req_i;
        ram_addr_a_o = m0_addr_i;
        ram_din_a_o  = m0_data_i;
        // A dropped request or the final allowed beat both end the burst.
        if (!m0_req_i || beat_cnt_q == LAST_BEAT) begin
          last_served_d = 1'b0;
          beat_cnt_d    = '0;
          if (m1_req_i) begin
            state_d = GRANT1;
          end else if (m0_req_i) begin
            state_d = GRANT0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end

      GRANT1: begin
        ram_we_a_o   = m1_req_i;
        ram_addr_a_o = m1_addr_i;
        ram_din_a_o  = m1_data_i;
        if (!m1_req_i || beat_cnt_q == LAST_BEAT) begin
          last_served_d = 1'b1;
          beat_cnt_d    = '0;
          if (m0_req_i) begin
            state_d = GRANT0;
          end else if (m1_req_i) begin
            state_d = GRANT1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_gnt_o = (state_q == GRANT0);
  assign m1_gnt_o = (state_q == GRANT1);

  assign ram_re_b_o   = rd_req_i;
  assign ram_addr_b_o = rd_addr_i;
  assign rd_valid_d   = rd_req_i;
  assign rd_valid_o   = rd_valid_q;

`ifdef DPRAM_WR_FWD_EN
  logic                 fwd_hit_q, fwd_hit_d;
  logic [RAM_WIDTH-1:0] fwd_data_q, fwd_data_d;

  // The RAM is read-first, so a same-address write must be bypassed to the reader.
  assign fwd_hit_d  = ram_we_a_o && rd_req_i && (ram_addr_a_o == rd_addr_i);
  assign fwd_data_d = ram_din_a_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rd_data_o = fwd_hit_q ? fwd_data_q : ram_dout_b_i;
`else
  assign rd_data_o = ram_dout_b_i;
`endif

endmodule

// File: tb/tb_dpram_write_arbiter.sv
// Testbench for dpram_write_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dpram_write_arbiter;
  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m1_req, rd_req;
  logic [AW-1:0] m0_addr, m1_addr, rd_addr;
  logic [W-1:0]  m0_data, m1_data;
  logic          m0_gnt, m1_gnt, rd_valid;
  logic [W-1:0]  rd_data;
  logic          ram_we_a, ram_re_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [W-1:0]  ram_din_a;
  logic [W-1:0]  ram_dout_b = '0;

  dpram_write_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .ram_we_a_o(ram_we_a), .ram_addr_a_o(ram_addr_a), .ram_din_a_o(ram_din_a),
    .ram_re_b_o(ram_re_b), .ram_addr_b_o(ram_addr_b), .ram_dout_b_i(ram_dout_b)
  );

  // Read-first dual-port RAM; output holds when not reading.
  logic [W-1:0] ram_mem [D] = '{default: '0};
  always @(posedge clk) begin
    if (ram_re_b) ram_dout_b <= ram_mem[ram_addr_b];
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 none), beats written in current burst, last served.
  int           m_owner, m_beats, m_last;
  logic         m_rv;
  logic [W-1:0] m_rd;
  logic [W-1:0] ref_mem [D] = '{default: '0};
  logic          e_g0, e_g1, e_we;
  logic [AW-1:0] e_addr;
  logic [W-1:0]  e_din;

  function automatic void model_outputs();
    e_g0 = (m_owner == 0);
    e_g1 = (m_owner == 1);
    e_we = 1'b0; e_addr = '0; e_din = '0;
    if (m_owner == 0) begin e_we = m0_req; e_addr = m0_addr; e_din = m0_data; end
    if (m_owner == 1) begin e_we = m1_req; e_addr = m1_addr; e_din = m1_data; end
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_last = 1; m_rv = 1'b0; m_rd = '0;
  endfunction

  task automatic advance();
    bit rq[2];
    int x;
    model_outputs();
    rq[0] = m0_req; rq[1] = m1_req;
    m_rv = rd_req;
    if (rd_req) begin
      m_rd = ref_mem[rd_addr];
`ifdef DPRAM_WR_FWD_EN
      if (e_we && e_addr == rd_addr) m_rd = e_din;
`endif
    end
    if (e_we) ref_mem[e_addr] = e_din;
    if (m_owner < 0) begin
      if (rq[0] && rq[1]) m_owner = 1 - m_last;
      else if (rq[0])     m_owner = 0;
      else if (rq[1])     m_owner = 1;
    end else begin
      x = m_owner;
      if (rq[x]) m_beats++;
      if (!rq[x] || m_beats == MB) begin
        m_last  = x;
        m_beats = 0;
        m_owner = rq[1-x] ? 1 - x : (rq[x] ? x : -1);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; rd_req = 0;
    m0_addr = '0; m1_addr = '0; rd_addr = '0; m0_data = '0; m1_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, rd_valid, ram_we_a} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: gnt0/gnt1/rv/we=%b expected 0000", {m0_gnt, m1_gnt, rd_valid, ram_we_a});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, rd_valid, ram_we_a} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: gnt0/gnt1/rv/we=%b expected 0000", {m0_gnt, m1_gnt, rd_valid, ram_we_a});
    end
    @(negedge clk);
  endtask

  task automatic test_single_m0();
    apply_reset();
    m0_req = 1; m0_addr = 10'h010; m0_data = 16'h00A0;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL single_idle_gnt: m0_gnt=%b expected 0", m0_gnt); end
    advance();
    for (int i = 0; i < 3; i++) begin
      m0_addr = AW'(10'h010 + i); m0_data = W'(16'h00A0 + i);
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt, ram_we_a} !== 3'b101 || ram_addr_a !== AW'(10'h010 + i) || ram_din_a !== W'(16'h00A0 + i)) begin
        n_fail++; $display("FAIL single_beat%0d: gnt=%b%b we=%b addr=%h din=%h expected gnt=10 we=1 addr=%h din=%h",
                           i, m0_gnt, m1_gnt, ram_we_a, ram_addr_a, ram_din_a, 10'h010 + i, 16'h00A0 + i);
      end
      advance();
    end
    m0_req = 0;
    advance();
    for (int i = 0; i < 4; i++) begin
      rd_req = (i < 3); rd_addr = AW'(10'h010 + i);
      #1;
      if (i > 0) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== W'(16'h00A0 + i - 1)) begin
          n_fail++; $display("FAIL single_read%0d: rv=%b data=%h expected rv=1 data=%h", i - 1, rd_valid, rd_data, 16'h00A0 + i - 1);
        end
      end
      advance();
    end
    #1;
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_rv_drop: rv=%b expected 0", rd_valid); end
    @(negedge clk);
  endtask

  task automatic test_both_bursts();
    int owner;
    apply_reset();
    m0_req = 1; m1_req = 1;
    advance();
    for (int k = 1; k <= 24; k++) begin
      m0_addr = AW'($urandom_range(0, 1023)); m0_data = W'($urandom);
      m1_addr = AW'($urandom_range(0, 1023)); m1_data = W'($urandom);
      owner = ((k - 1) / MB) % 2;
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== (owner == 0 ? 2'b10 : 2'b01) || ram_we_a !== 1'b1 ||
          ram_addr_a !== (owner == 0 ? m0_addr : m1_addr)) begin
        n_fail++; $display("FAIL both_cycle%0d: gnt=%b%b we=%b addr=%h expected owner M%0d writing", k, m0_gnt, m1_gnt, ram_we_a, ram_addr_a, owner);
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_drop_after_2();
    int m0_writes = 0;
    apply_reset();
    m0_req = 1; m1_req = 1; m0_addr = 10'h040; m1_addr = 10'h050;
    advance();
    for (int k = 1; k <= 5; k++) begin
      m0_req = (k <= 2);
      #1;
      if (m0_gnt && ram_we_a) m0_writes++;
      if (k == 4) begin
        n_checks++;
        if ({m0_gnt, m1_gnt, ram_we_a} !== 3'b011) begin
          n_fail++; $display("FAIL drop_handoff: gnt=%b%b we=%b expected gnt=01 we=1", m0_gnt, m1_gnt, ram_we_a);
        end
      end
      advance();
    end
    n_checks++;
    if (m0_writes != 2) begin n_fail++; $display("FAIL drop_m0_beats: got %0d expected 2", m0_writes); end
    idle_inputs();
    advance();
  endtask

  task automatic test_collision();
    logic [W-1:0] exp_rd;
`ifdef DPRAM_WR_FWD_EN
    exp_rd = 16'h5555;
`else
    exp_rd = 16'h1111;
`endif
    apply_reset();
    m0_req = 1; m0_addr = 10'h020; m0_data = 16'h1111;
    advance();
    advance();
    m0_data = 16'h5555; rd_req = 1; rd_addr = 10'h020;
    advance();
    m0_req = 0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
      n_fail++; $display("FAIL collision_read: rv=%b data=%h expected rv=1 data=%h", rd_valid, rd_data, exp_rd);
    end
    advance();
    rd_req = 0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5555) begin
      n_fail++; $display("FAIL collision_reread: rv=%b data=%h expected rv=1 data=5555", rd_valid, rd_data);
    end
    advance();
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    m1_req = 1; m1_addr = 10'h100; m1_data = 16'hB000;
    advance();
    for (int b = 0; b < 3; b++) begin
      m1_addr = AW'(10'h100 + b); m1_data = W'(16'hB000 + b);
      rd_req = (b == 2); rd_addr = 10'h200;
      advance();
    end
    m1_addr = 10'h103; m1_data = 16'hB003; rd_req = 0;
    #1;
    n_checks++;
    if ({m1_gnt, ram_we_a, rd_valid} !== 3'b111) begin
      n_fail++; $display("FAIL midburst_pre: gnt1/we/rv=%b expected 111", {m1_gnt, ram_we_a, rd_valid});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_we_a, rd_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL midburst_async: gnt0/gnt1/we/rv=%b expected 0000", {m0_gnt, m1_gnt, ram_we_a, rd_valid});
    end
    @(negedge clk);
    model_reset();
    idle_inputs();
    rst = 1'b0;
    m0_req = 1; m1_req = 1; m0_addr = 10'h300; m1_addr = 10'h301;
    rd_req = 1; rd_addr = 10'h103;
    advance();
    rd_addr = 10'h102;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL midburst_first_gnt: gnt=%b%b expected 10", m0_gnt, m1_gnt); end
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL midburst_beat_dropped: rv=%b data=%h expected rv=1 data=0000", rd_valid, rd_data);
    end
    advance();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hB002) begin
      n_fail++; $display("FAIL midburst_beat3: rv=%b data=%h expected rv=1 data=b002", rd_valid, rd_data);
    end
    advance();
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      m0_req  = ($urandom_range(0, 9) < 8);
      m1_req  = ($urandom_range(0, 9) < 7);
      m0_addr = AW'($urandom_range(0, 15)); m0_data = W'($urandom);
      m1_addr = AW'($urandom_range(0, 15)); m1_data = W'($urandom);
      rd_req  = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, 15));
      #1;
      model_outputs();
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {e_g0, e_g1} || (m0_gnt && m1_gnt)) begin
        n_fail++; $display("FAIL rand_gnt c=%0d: gnt=%b%b expected %b%b", c, m0_gnt, m1_gnt, e_g0, e_g1);
      end
      n_checks++;
      if (ram_we_a !== e_we || ram_addr_a !== e_addr || ram_din_a !== e_din) begin
        n_fail++; $display("FAIL rand_write c=%0d: we=%b addr=%h din=%h expected we=%b addr=%h din=%h",
                           c, ram_we_a, ram_addr_a, ram_din_a, e_we, e_addr, e_din);
      end
      n_checks++;
      if (ram_re_b !== rd_req || ram_addr_b !== rd_addr || rd_valid !== m_rv || (m_rv && rd_data !== m_rd)) begin
        n_fail++; $display("FAIL rand_read c=%0d: re=%b raddr=%h rv=%b data=%h expected rv=%b data=%h",
                           c, ram_re_b, ram_addr_b, rd_valid, rd_data, m_rv, m_rd);
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_single_m0();
    test_both_bursts();
    test_drop_after_2();
    test_collision();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
